// File: rtl/sop_mac_stream.sv
// Streaming sum-of-products unit: accumulates N_TERMS products A*B from a valid/ready
// input stream and presents the saturated or wrapped dot product on a held output.
module sop_mac_stream #(
  parameter int DATA_W  = 8,
  parameter int N_TERMS = 3,
  parameter int OUT_W   = 8,
  parameter int SAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              overflow,
  output logic              busy
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_TERMS+1);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS-1);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, prod, sum;
  logic [CNT_W-1:0] count;
  logic             beat, accept, sum_ovf;
  logic [OUT_W-1:0] sum_out;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the output side holds data/overflow until accepted.
  assign in_ready = (state == ST_ACC) && !reset && !flush;
  assign beat     = in_valid && in_ready;
  assign accept   = out_valid && out_ready;

  assign prod = ACC_W'(a_in) * ACC_W'(b_in);
  assign sum  = acc + prod;

  generate
    if (OUT_W < ACC_W) begin : g_ovf
      assign sum_ovf = |sum[ACC_W-1:OUT_W];
    end else begin : g_no_ovf
      assign sum_ovf = 1'b0;
    end
  endgenerate

  assign sum_out = ((SAT != 0) && sum_ovf) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
  assign busy    = (count != '0) || out_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (beat && (count == LAST)) state_nxt = ST_DONE;
      ST_DONE: if (accept)                  state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
    if (flush) state_nxt = ST_ACC;
  end

  // out_data is deliberately left untouched by flush so the last delivered value persists.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (beat) begin
        if (count == LAST) begin
          acc       <= '0;
          count     <= '0;
          out_valid <= 1'b1;
          out_data  <= sum_out;
          overflow  <= sum_ovf;
        end else begin
          acc   <= sum;
          count <= count + 1'b1;
        end
      end
      if (accept) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sop_mac_stream.sv
// Directed bench for sop_mac_stream: three 3-term instances (16-bit, 8-bit saturating,
// 8-bit wrapping) share one stream; a 1-term instance is exercised separately.
module tb_sop_mac_stream;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready, in_valid_d;
  logic [7:0] a_in, b_in;

  logic        in_ready_a, out_valid_a, overflow_a, busy_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, overflow_b, busy_b;
  logic [7:0]  out_data_b;
  logic        in_ready_c, out_valid_c, overflow_c, busy_c;
  logic [7:0]  out_data_c;
  logic        in_ready_d, out_valid_d, overflow_d, busy_d;
  logic [15:0] out_data_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sop_mac_stream #(.DATA_W(8), .N_TERMS(3), .OUT_W(16), .SAT(1)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .overflow(overflow_a), .busy(busy_a));

  sop_mac_stream #(.DATA_W(8), .N_TERMS(3), .OUT_W(8), .SAT(1)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .overflow(overflow_b), .busy(busy_b));

  sop_mac_stream #(.DATA_W(8), .N_TERMS(3), .OUT_W(8), .SAT(0)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .overflow(overflow_c), .busy(busy_c));

  sop_mac_stream #(.DATA_W(8), .N_TERMS(1), .OUT_W(16), .SAT(1)) u_d (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_d), .out_ready(out_ready),
    .out_data(out_data_d), .overflow(overflow_d), .busy(busy_d));

  typedef struct {
    logic [2:0][7:0] a;
    logic [2:0][7:0] b;
    logic [15:0]     exp_a;
    logic            ov_a;
    logic [7:0]      exp_b;
    logic [7:0]      exp_c;
    logic            ov_8;
  } vec_t;

  localparam int NV = 7;
  vec_t vec[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] a0, b0, a1, b1, a2, b2,
                         input logic [15:0] ea, input logic oa,
                         input logic [7:0] eb, ec, input logic o8);
    vec[i].a[0] = a0; vec[i].b[0] = b0;
    vec[i].a[1] = a1; vec[i].b[1] = b1;
    vec[i].a[2] = a2; vec[i].b[2] = b2;
    vec[i].exp_a = ea; vec[i].ov_a = oa;
    vec[i].exp_b = eb; vec[i].exp_c = ec; vec[i].ov_8 = o8;
  endtask

  // Presents one pair and returns just after the edge that accepted it.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1;
    while (!in_ready_a && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called at a negedge with out_valid high; consumes the result.
  task automatic accept_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a0, b0, a1, b1, a2, b2);
    send_pair(a0, b0);
    send_pair(a1, b1);
    send_pair(a2, b2);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid_d = 1'b0;
    out_ready = 1'b0; a_in = '0; b_in = '0;

    set_vec(0,   1,   2,   3,   4,   5,   6,    16'd44, 1'b0,   8'd44,  8'd44, 1'b0);
    set_vec(1, 255, 255, 255, 255, 255, 255, 16'hFFFF, 1'b1,  8'd255,  8'h03, 1'b1);
    set_vec(2,  10,  20,   3,   3,   0,   0,   16'd209, 1'b0,  8'd209, 8'd209, 1'b0);
    set_vec(3,  16,  16,   0,   5,   0,   0,   16'd256, 1'b0,  8'd255,   8'd0, 1'b1);
    set_vec(4,  15,  17,   0,   0,   0,   0,   16'd255, 1'b0,  8'd255, 8'd255, 1'b0);
    set_vec(5,   0,   0,   0,   0,   0,   0,     16'd0, 1'b0,    8'd0,   8'd0, 1'b0);
    set_vec(6, 100, 100, 200, 200,  50,  50, 16'd52500, 1'b0,  8'd255,  8'd20, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready_low", in_ready_a, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_in_ready", in_ready_a, 1);

    // Table: back-to-back triples, result expected the cycle after the last beat
    for (int i = 0; i < NV; i++) begin
      send3(vec[i].a[0], vec[i].b[0], vec[i].a[1], vec[i].b[1], vec[i].a[2], vec[i].b[2]);
      check("vec_valid", out_valid_a, 1);
      check("vec_data16", out_data_a, vec[i].exp_a);
      check("vec_ovf16", overflow_a, vec[i].ov_a);
      check("vec_data8_sat", out_data_b, vec[i].exp_b);
      check("vec_ovf8_sat", overflow_b, vec[i].ov_8);
      check("vec_data8_wrap", out_data_c, vec[i].exp_c);
      check("vec_ovf8_wrap", overflow_c, vec[i].ov_8);
      accept_result();
      @(negedge clk);
      check("vec_valid_drop", out_valid_a, 0);
    end

    // Back-pressure: result held while out_ready is low, inputs refused
    send3(2, 3, 1, 1, 4, 4);
    a_in = 8'd9; b_in = 8'd9; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", out_valid_a, 1);
      check("hold_data", out_data_a, 23);
      check("hold_in_ready", in_ready_a, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    accept_result();
    @(negedge clk);
    check("release_valid", out_valid_a, 0);
    check("release_in_ready", in_ready_a, 1);
    check("release_busy", busy_a, 0);

    // Bubbles between beats
    for (int k = 0; k < 3; k++) begin
      send_pair(2, 2);
      if (k < 2) begin
        repeat (2) @(negedge clk);
        check("gap_no_result", out_valid_a, 0);
        check("gap_busy", busy_a, 1);
      end
    end
    @(negedge clk);
    check("gap_valid", out_valid_a, 1);
    check("gap_data", out_data_a, 12);
    accept_result();

    // Flush mid-accumulation with a simultaneous beat
    send_pair(5, 5);
    send_pair(5, 5);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; a_in = 8'd9; b_in = 8'd9;
    #1 check("flush_in_ready", in_ready_a, 0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", busy_a, 0);
    check("flush_keeps_data", out_data_a, 12);
    send3(1, 1, 1, 1, 1, 1);
    check("post_flush_valid", out_valid_a, 1);
    check("post_flush_data", out_data_a, 3);
    accept_result();

    // Flush while a result is held, racing an accept
    send3(2, 1, 1, 1, 1, 1);
    check("done_flush_pre", out_data_a, 4);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("done_flush_valid", out_valid_a, 0);
    check("done_flush_data", out_data_a, 4);
    check("done_flush_in_ready", in_ready_a, 1);

    // Reset mid-accumulation
    send_pair(9, 9);
    send_pair(9, 9);
    @(negedge clk);
    reset = 1'b1;
    #1 check("mid_rst_in_ready", in_ready_a, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_data", out_data_a, 0);

    // Reset while a saturated result is held
    send3(255, 255, 255, 255, 255, 255);
    check("done_rst_pre_ovf", overflow_b, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("done_rst_valid", out_valid_a, 0);
    check("done_rst_data", out_data_a, 0);
    check("done_rst_ovf", overflow_b, 0);
    check("done_rst_in_ready", in_ready_a, 1);
    send3(7, 1, 0, 9, 1, 1);
    check("post_rst_valid", out_valid_a, 1);
    check("post_rst_data", out_data_a, 8);
    accept_result();

    // Single-term instance: every beat is a result
    @(negedge clk);
    a_in = 8'd6; b_in = 8'd7; in_valid_d = 1'b1;
    @(posedge clk);
    #1 in_valid_d = 1'b0;
    @(negedge clk);
    check("n1_valid", out_valid_d, 1);
    check("n1_data", out_data_d, 42);
    check("n1_in_ready", in_ready_d, 0);
    accept_result();
    @(negedge clk);
    check("n1_in_ready_back", in_ready_d, 1);
    a_in = 8'd3; b_in = 8'd3; in_valid_d = 1'b1;
    @(posedge clk);
    #1 in_valid_d = 1'b0;
    @(negedge clk);
    check("n1_data2", out_data_d, 9);
    accept_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
